// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, frame constants, baud divisor helper.
// Combinational only; no latency or flow control of its own.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Rounded to nearest so the bit period error stays within half a clock.
    function automatic int clks_per_bit(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the transmit arbiter (master) and the UART serializer (slave).
// Arbiter raises tx_start with tx_data; it paces further bytes on uart_busy.
interface uart_tx_serializer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       uart_busy;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_start,
        output tx_data,
        input  uart_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output uart_busy,
        output tx_done,
        output tx
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// bit_end is combinational from the count; clear holds the count at zero.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_baud_cnt;
    logic             w_at_last;

    assign w_at_last = (r_baud_cnt == LAST);
    assign o_bit_end = w_at_last && !i_clear;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_baud_cnt <= '0;
        end else if (i_clear || w_at_last) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: start bit on the edge after acceptance, 10*CLKS_PER_BIT frame.
// One byte in flight; tx_start outside IDLE is ignored, callers pace on uart_busy.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE)
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    uart_tx_serializer_if.slave         io_tx_if
);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_nxt;
    logic       r_tx;
    logic       w_tx_nxt;
    logic       r_busy;
    logic       r_done;
    logic       w_done_nxt;
    logic       w_bit_end;
    logic       w_clear;

    // Counter is held at zero while idle so the start bit gets a full period.
    assign w_clear = (r_state == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_clear),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = r_tx;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (io_tx_if.tx_start) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = io_tx_if.tx_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Next bit is driven from the pre-shift bit 1, i.e. the new bit 0.
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign io_tx_if.tx        = r_tx;
    assign io_tx_if.uart_busy = r_busy;
    assign io_tx_if.tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=10, with a line receiver
// that decodes frames independently of the DUT state.
module tb_uart_tx_serializer;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    uart_tx_serializer_if bus ();

    uart_tx_serializer #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .io_tx_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver: finds the start bit, samples mid-bit at 10 clocks per bit.
    logic       rx_en   = 1'b0;
    int         rx_ferr = 0;
    logic [7:0] rx_q[$];

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && bus.tx === 1'b0) begin
                repeat (15) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    b[j] = bus.tx;
                    if (j < 7) repeat (10) @(negedge clk);
                end
                repeat (10) @(negedge clk);
                if (bus.tx !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},   32'(bus.tx),        32'd1);
        chk({tag, "_busy"}, 32'(bus.uart_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.tx_done),   32'd0);
    endtask

    // Entered #1 after the acceptance edge; leaves #1 after the stop-bit-end edge.
    // At frame cycle inj a competing request for 8'h3C is raised for one cycle.
    task automatic check_frame(input logic [7:0] d, input string tag, input int inj);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 100; i++) begin
            if (i == inj) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h3C;
            end
            if (i == inj + 1) bus.tx_start = 1'b0;
            chk({tag, "_tx"},   32'(bus.tx),        32'(fr[i / 10]));
            chk({tag, "_busy"}, 32'(bus.uart_busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.tx_done),   32'd0);
            tick();
        end
        chk({tag, "_end_busy"}, 32'(bus.uart_busy), 32'd0);
        chk({tag, "_end_done"}, 32'(bus.tx_done),   32'd1);
        chk({tag, "_end_tx"},   32'(bus.tx),        32'd1);
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int n;
        n = 0;
        while (bus.uart_busy !== v && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.uart_busy), 32'(v));
    endtask

    logic [7:0] msg [4] = '{8'hD1, 8'h03, 8'h7E, 8'h0A};

    initial begin
        rst_n        = 1'b0;
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hFF;

        // 1. Reset for 3 cycles with a request pending: reset wins.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("reset");
        end
        bus.tx_start = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("post_reset");
        end

        // 2. Single byte A5.
        bus.tx_data  = 8'hA5;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        check_frame(8'hA5, "a5", 1000);
        tick();
        chk_idle("a5_after");

        // 3. Back-to-back 00 then FF with tx_start held.
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_data  = 8'hFF;
        check_frame(8'h00, "b2b_00", 1000);
        tick();
        bus.tx_start = 1'b0;
        check_frame(8'hFF, "b2b_ff", 1000);
        tick();
        chk_idle("b2b_after");

        // 4. Request during an 81 frame is ignored and not queued.
        bus.tx_data  = 8'h81;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        check_frame(8'h81, "ign_81", 40);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("ign_after");
        end

        // 5. Reset during data bit 3 (bit value 0 so the line jump is visible).
        bus.tx_data  = 8'h52;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        repeat (44) tick();
        chk("rst_mid_bit3", 32'(bus.tx), 32'd0);
        chk("rst_mid_busy", 32'(bus.uart_busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_idle("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk_idle("rst_mid_after");
        end
        bus.tx_data  = 8'hC3;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        check_frame(8'hC3, "rst_c3", 1000);
        tick();
        chk_idle("rst_c3_after");

        // 6. Sender paced on uart_busy, decoded by the line receiver.
        rx_en        = 1'b1;
        bus.tx_data  = msg[0];
        bus.tx_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy(1'b1, "arb_busy_rise");
            if (k < 3) bus.tx_data  = msg[k + 1];
            else       bus.tx_start = 1'b0;
            wait_busy(1'b0, "arb_busy_fall");
        end
        repeat (20) tick();
        chk("arb_count", 32'(rx_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < rx_q.size()) chk("arb_byte", 32'(rx_q[k]), 32'(msg[k]));
        end
        chk("arb_framing", 32'(rx_ferr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
